// File: rtl/elastic_skid_pkg.sv
// Shared types and constants for the elastic_skid two-entry skid buffer.
package elastic_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int StallCountWidth = 16;

endpackage : elastic_skid_pkg

// File: rtl/elastic_skid_stats.sv
// Saturating counter of output stall cycles for elastic_skid.
// Only instantiated when ELASTIC_SKID_STATS_EN is defined.
module elastic_skid_stats
  import elastic_skid_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       stall,
  output logic [StallCountWidth-1:0] stall_count
);

  // Stops at all-ones so a long stall never wraps back to a small value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule : elastic_skid_stats

// File: rtl/elastic_skid.sv
// Two-entry skid buffer cutting both the valid/data and the ready paths.
// Optional stall statistics (stall_count_o, full_o) under ELASTIC_SKID_STATS_EN.
module elastic_skid
  import elastic_skid_pkg::*;
#(
  parameter int unsigned DataWidth        = 8,
  parameter bit          ClearDataOnReset = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [DataWidth-1:0]       data_o,
  input  logic                       ready_i
`ifdef ELASTIC_SKID_STATS_EN
  ,
  output logic [StallCountWidth-1:0] stall_count_o,
  output logic                       full_o
`endif
);

  state_t               state_q, state_d;
  logic [DataWidth-1:0] main_q, skid_q, main_d;
  logic                 main_en, skid_en;
  logic                 in_fire, out_fire;

  // Both handshake outputs decode the registered state only.
  assign valid_o  = (state_q != EMPTY);
  assign ready_o  = (state_q != FULL);
  assign data_o   = main_q;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = data_i;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Skid beat is younger than main, so it moves forward on drain.
        if (ready_i) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  generate
    if (ClearDataOnReset) begin : g_data_clear
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          if (main_en) main_q <= main_d;
          if (skid_en) skid_q <= data_i;
        end
      end
    end else begin : g_data_keep
      // No reset on the payload; loads are blocked while reset is held.
      always_ff @(posedge clk_i) begin
        if (main_en && !reset_i) main_q <= main_d;
        if (skid_en && !reset_i) skid_q <= data_i;
      end
    end
  endgenerate

`ifdef ELASTIC_SKID_STATS_EN
  assign full_o = (state_q == FULL);

  elastic_skid_stats u_stats (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .stall       (valid_o && !ready_i),
    .stall_count (stall_count_o)
  );
`endif

endmodule : elastic_skid

// File: tb/tb_elastic_skid.sv
// Directed and scoreboarded bench for elastic_skid (ClearDataOnReset=1).
// Stall statistics are exercised when ELASTIC_SKID_STATS_EN is defined.
module tb_elastic_skid;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
`ifdef ELASTIC_SKID_STATS_EN
  logic [15:0] stall_count_o;
  logic        full_o;
`endif

  int error_count = 0;
  int check_count = 0;

  elastic_skid #(
    .DataWidth        (8),
    .ClearDataOnReset (1'b1)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef ELASTIC_SKID_STATS_EN
    ,
    .stall_count_o (stall_count_o),
    .full_o        (full_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Safety net in case the DUT or bench stalls forever.
  initial begin
    #3_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] q[$];
    int         delivered;
    logic       last_in_fire;
    logic       held;
    logic [7:0] held_data;
    logic       in_f, out_f;

    reset_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #3;
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_data", data_o, 8'h00);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Full-throughput streaming 01..10
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        checkOutput("stream_valid", valid_o, 1'b1);
        checkOutput("stream_data", data_o, 8'(i));
        checkOutput("stream_ready", ready_o, 1'b1);
      end
      applyStimulus(1'b1, 8'(i + 1), 1'b1);
    end
    @(negedge clk_i);
    checkOutput("stream_last_data", data_o, 8'h10);
    checkOutput("stream_last_valid", valid_o, 1'b1);
    checkOutput("stream_last_ready", ready_o, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk_i);
    checkOutput("stream_empty", valid_o, 1'b0);

    // Skid fill: A1 in main, B2 into skid under backpressure
    applyStimulus(1'b1, 8'hA1, 1'b0);
    @(negedge clk_i);
    checkOutput("fill_busy_valid", valid_o, 1'b1);
    checkOutput("fill_busy_data", data_o, 8'hA1);
    checkOutput("fill_busy_ready", ready_o, 1'b1);
    applyStimulus(1'b1, 8'hB2, 1'b0);
    @(negedge clk_i);
    checkOutput("fill_full_ready", ready_o, 1'b0);
    checkOutput("fill_full_data", data_o, 8'hA1);
    checkOutput("fill_full_valid", valid_o, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("hold_data", data_o, 8'hA1);
      checkOutput("hold_ready", ready_o, 1'b0);
    end

    // Drain: A1 consumed now, then B2, then empty
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk_i);
    checkOutput("drain_b2_data", data_o, 8'hB2);
    checkOutput("drain_b2_valid", valid_o, 1'b1);
    checkOutput("drain_ready_back", ready_o, 1'b1);
    @(negedge clk_i);
    checkOutput("drain_empty", valid_o, 1'b0);
    checkOutput("drain_empty_ready", ready_o, 1'b1);

    // Asynchronous reset while FULL discards both entries
    applyStimulus(1'b1, 8'h33, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b1, 8'h44, 1'b0);
    @(negedge clk_i);
    checkOutput("midrst_pre_ready", ready_o, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midrst_valid", valid_o, 1'b0);
    checkOutput("midrst_ready", ready_o, 1'b1);
    checkOutput("midrst_data", data_o, 8'h00);
    @(negedge clk_i);
    reset_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk_i);
    checkOutput("midrst_discard", valid_o, 1'b0);

    // Random valid/ready against a two-deep FIFO model
    delivered    = 0;
    last_in_fire = 1'b1;
    held         = 1'b0;
    held_data    = 8'h00;
    for (int cyc = 0; cyc < 20000 && delivered < 2000; cyc++) begin
      @(negedge clk_i);
      checkOutput("rnd_valid", valid_o, q.size() > 0);
      checkOutput("rnd_ready", ready_o, q.size() < 2);
      if (q.size() > 0) checkOutput("rnd_data", data_o, q[0]);
      if (held) checkOutput("rnd_hold", data_o, held_data);
      if (!(valid_i && !last_in_fire)) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = 8'($urandom);
      end
      ready_i   = 1'($urandom_range(0, 1));
      out_f     = valid_o && ready_i;
      in_f      = valid_i && ready_o;
      held      = valid_o && !ready_i;
      held_data = data_o;
      if (out_f) begin
        void'(q.pop_front());
        delivered++;
      end
      if (in_f) q.push_back(data_i);
      last_in_fire = in_f;
    end
    checkOutput("rnd_delivered", delivered >= 2000, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge clk_i);
    checkOutput("rnd_final_empty", valid_o, 1'b0);

`ifdef ELASTIC_SKID_STATS_EN
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    checkOutput("stats_rst_count", stall_count_o, 16'h0000);
    applyStimulus(1'b1, 8'hA1, 1'b0);
    @(negedge clk_i);
    checkOutput("stats_busy_count", stall_count_o, 16'h0000);
    checkOutput("stats_busy_full", full_o, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0);
    @(negedge clk_i);
    checkOutput("stats_full_count", stall_count_o, 16'h0001);
    checkOutput("stats_full_flag", full_o, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk_i);
    checkOutput("stats_count4", stall_count_o, 16'h0004);
    repeat (70000) @(negedge clk_i);
    checkOutput("stats_saturated", stall_count_o, 16'hFFFF);
    checkOutput("stats_still_full", full_o, 1'b1);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("stats_reset_count", stall_count_o, 16'h0000);
    checkOutput("stats_reset_full", full_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule : tb_elastic_skid
